edge_pulse_generator: RTL and testbench

- Generates programmable bursts of rising edges on a single-bit output: N pulses, each H cycles high and L cycles low.
- It is the stimulus/transmit side for the team's positive edge detector.
- Each rising edge it emits is also flagged on a one-cycle strobe, so a bench or downstream checker can compare that strobe directly against the detector's pos_edge_detected.

---
 rtl/edge_pulse_generator_if.sv | 26 ++
 rtl/edge_pulse_generator.sv | 131 +++++++++++++
 tb/tb_edge_pulse_generator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/edge_pulse_generator_if.sv
// rtl/edge_pulse_generator_if.sv - control/status bundle for the edge pulse generator
interface edge_pulse_generator_if #(
    parameter int CNT_W = 8,
    parameter int WID_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_pulses;
    logic [WID_W-1:0] high_cycles;
    logic [WID_W-1:0] low_cycles;
    logic             sig_out;
    logic             edge_strobe;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_sent;

    modport master (
        output start, abort, num_pulses, high_cycles, low_cycles,
        input  sig_out, edge_strobe, busy, done, pulses_sent
    );

    modport slave (
        input  start, abort, num_pulses, high_cycles, low_cycles,
        output sig_out, edge_strobe, busy, done, pulses_sent
    );
endinterface

// File: rtl/edge_pulse_generator.sv
// rtl/edge_pulse_generator.sv - bursts of N pulses, H high / L low, with rising-edge strobe
// Optional continuous mode (num_pulses=0 start) under `define EDGE_GEN_CONT_EN.
module edge_pulse_generator #(
    parameter int CNT_W = 8,
    parameter int WID_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    edge_pulse_generator_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [WID_W-1:0] W_ONE = {{(WID_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_num;
    logic [WID_W-1:0] r_high;
    logic [WID_W-1:0] r_low;
    logic [WID_W-1:0] r_phase;
    logic [CNT_W-1:0] r_sent;
    logic             r_cont;
    logic             r_sig;
    logic             r_strobe;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [WID_W-1:0] w_high_eff;
    logic [WID_W-1:0] w_low_eff;
    logic [CNT_W-1:0] w_sent_inc;

`ifdef EDGE_GEN_CONT_EN
    assign w_accept = (r_state == S_IDLE) && bus.start;
`else
    assign w_accept = (r_state == S_IDLE) && bus.start && (bus.num_pulses != '0);
`endif

    // A zero phase length would never let the phase counter match, so clamp to 1.
    assign w_high_eff = (bus.high_cycles == '0) ? W_ONE : bus.high_cycles;
    assign w_low_eff  = (bus.low_cycles  == '0) ? W_ONE : bus.low_cycles;
    assign w_last     = !r_cont && (r_sent == r_num);
    assign w_sent_inc = (r_sent == {CNT_W{1'b1}}) ? r_sent : r_sent + C_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_num    <= '0;
            r_high   <= '0;
            r_low    <= '0;
            r_phase  <= '0;
            r_sent   <= '0;
            r_cont   <= 1'b0;
            r_sig    <= 1'b0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_num    <= bus.num_pulses;
                        r_high   <= w_high_eff;
                        r_low    <= w_low_eff;
                        r_cont   <= (bus.num_pulses == '0);
                        r_state  <= S_HIGH;
                        r_phase  <= W_ONE;
                        r_sent   <= C_ONE;
                        r_sig    <= 1'b1;
                        r_strobe <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_phase <= '0;
                        r_sig   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_phase == r_high) begin
                        r_sig <= 1'b0;
                        // The final high phase ends the burst directly, with no trailing low.
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_phase <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOW;
                            r_phase <= W_ONE;
                        end
                    end else begin
                        r_phase <= r_phase + W_ONE;
                    end
                end
                S_LOW: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_phase <= '0;
                        r_sig   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_phase == r_low) begin
                        r_state  <= S_HIGH;
                        r_phase  <= W_ONE;
                        r_sig    <= 1'b1;
                        r_strobe <= 1'b1;
                        r_sent   <= w_sent_inc;
                    end else begin
                        r_phase <= r_phase + W_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sig   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sig_out     = r_sig;
    assign bus.edge_strobe = r_strobe;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pulses_sent = r_sent;
endmodule

// File: tb/tb_edge_pulse_generator.sv
// tb/tb_edge_pulse_generator.sv - directed self-checking bench for edge_pulse_generator
module tb_edge_pulse_generator;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    edge_pulse_generator_if #(.CNT_W(8), .WID_W(8)) bus ();

    edge_pulse_generator #(.CNT_W(8), .WID_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Vectors hold one bit per cycle after acceptance (bit c = cycle c).
    // A second start (inj_*) and/or abort can be raised during a given cycle.
    task automatic burst(input string tag, input int n, input int h, input int l, input int len,
                         input logic [31:0] v_sig, input logic [31:0] v_stb,
                         input logic [31:0] v_bsy, input logic [31:0] v_dn,
                         input int inj_c, input int inj_n, input int inj_h, input int inj_l,
                         input int ab_c, input int exp_sent);
        bus.num_pulses  = 8'(n);
        bus.high_cycles = 8'(h);
        bus.low_cycles  = 8'(l);
        bus.start       = 1'b1;
        tick();
        for (int c = 1; c <= len; c++) begin
            bus.start = 1'b0;
            bus.abort = 1'b0;
            chk($sformatf("%s c%0d {sig,stb,busy,done}", tag, c),
                {28'd0, bus.sig_out, bus.edge_strobe, bus.busy, bus.done},
                {28'd0, v_sig[c], v_stb[c], v_bsy[c], v_dn[c]});
            if (c == inj_c) begin
                bus.start       = 1'b1;
                bus.num_pulses  = 8'(inj_n);
                bus.high_cycles = 8'(inj_h);
                bus.low_cycles  = 8'(inj_l);
            end
            if (c == ab_c) bus.abort = 1'b1;
            if (c < len) tick();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk({tag, " pulses_sent"}, {24'd0, bus.pulses_sent}, 32'(exp_sent));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_pulses = '0;
        bus.high_cycles = '0;
        bus.low_cycles = '0;
        tick();
        tick();
        chk("reset outputs", {27'd0, bus.sig_out, bus.edge_strobe, bus.busy, bus.done, 1'b0},
            32'd0);
        chk("reset pulses_sent", {24'd0, bus.pulses_sent}, 32'd0);
        rst_n = 1'b1;
        tick();

        // N=3 H=2 L=3: rises 1,6,11; done 13.
        burst("basic", 3, 2, 3, 13, 32'h18C6, 32'h0842, 32'h1FFE, 32'h2000, 0, 0, 0, 0, 0, 3);
        tick();

        // N=4 H=0 L=0: period 2, rises 1,3,5,7; done 8.
        burst("zero_wid", 4, 0, 0, 8, 32'h00AA, 32'h00AA, 32'h00FE, 32'h0100, 0, 0, 0, 0, 0, 4);
        tick();

        // Same as basic with a busy-time start (N=5) that must be ignored.
        burst("ign_start", 3, 2, 3, 13, 32'h18C6, 32'h0842, 32'h1FFE, 32'h2000, 3, 5, 1, 1, 0, 3);
        tick();

        bus.num_pulses = 8'd0;
        bus.high_cycles = 8'd2;
        bus.low_cycles = 8'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("n0 start busy", {31'd0, bus.busy}, 32'd0);
        chk("n0 start sig", {31'd0, bus.sig_out}, 32'd0);
        chk("n0 start sent", {24'd0, bus.pulses_sent}, 32'd3);
        tick();
        chk("n0 start busy later", {31'd0, bus.busy}, 32'd0);

        // N=10 H=3 L=3, abort during cycle 8 together with an ignored start.
        burst("abort", 10, 3, 3, 9, 32'h018E, 32'h0082, 32'h01FE, 32'h0000, 8, 2, 1, 1, 8, 2);
        tick();
        chk("abort stays idle", {30'd0, bus.busy, bus.sig_out}, 32'd0);
        chk("abort no done", {31'd0, bus.done}, 32'd0);

        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle abort busy", {31'd0, bus.busy}, 32'd0);
        chk("idle abort sent", {24'd0, bus.pulses_sent}, 32'd2);

        // N=2 H=1 L=1 then a start in the done cycle (4): N=1 H=2 L=1.
        burst("b2b", 2, 1, 1, 7, 32'h006A, 32'h002A, 32'h006E, 32'h0090, 4, 1, 2, 1, 0, 1);
        tick();

        bus.num_pulses = 8'd3;
        bus.high_cycles = 8'd4;
        bus.low_cycles = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("pre-reset sig", {31'd0, bus.sig_out}, 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid reset outputs", {28'd0, bus.sig_out, bus.edge_strobe, bus.busy, bus.done},
            32'd0);
        chk("mid reset sent", {24'd0, bus.pulses_sent}, 32'd0);
        tick();
        chk("post reset done", {30'd0, bus.busy, bus.done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
